// File: rtl/cache_tag_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cache_tag_ctrl
// Purpose  : Tag/valid lookup and miss-handling controller for one
//            set-associative cache; drives the per-set PLRU bank.
// Revision : 1.0 - initial release
// ============================================================================
module cache_tag_ctrl #(
  parameter int ASSOC_NUM = 4,
  parameter int SET_NUM   = 64,
  parameter int TAG_WIDTH = 20,
  parameter int IDX_W     = $clog2(SET_NUM),
  parameter int WAY_W     = $clog2(ASSOC_NUM)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [IDX_W-1:0]     req_index,
  input  logic [TAG_WIDTH-1:0] req_tag,
  output logic                 resp_valid,
  output logic                 resp_hit,
  output logic [WAY_W-1:0]     resp_way,
  output logic                 refill_req_valid,
  input  logic                 refill_req_ready,
  output logic [IDX_W-1:0]     refill_req_index,
  output logic [TAG_WIDTH-1:0] refill_req_tag,
  output logic [WAY_W-1:0]     refill_req_way,
  input  logic                 refill_done,
  output logic [IDX_W-1:0]     plru_index,
  output logic [ASSOC_NUM-1:0] plru_access,
  output logic                 plru_update,
  input  logic [WAY_W-1:0]     plru_lru,
  input  logic                 flush_valid,
  output logic                 flush_done
);

  localparam logic [2:0] c_FLUSH       = 3'd0;
  localparam logic [2:0] c_IDLE        = 3'd1;
  localparam logic [2:0] c_LOOKUP      = 3'd2;
  localparam logic [2:0] c_MISS_REQ    = 3'd3;
  localparam logic [2:0] c_REFILL_WAIT = 3'd4;

  localparam logic [IDX_W-1:0]     c_LAST_SET = IDX_W'(SET_NUM - 1);
  localparam logic [ASSOC_NUM-1:0] c_ONE_WAY  = ASSOC_NUM'(1);

  logic [2:0]           r_state;
  logic [2:0]           w_next_state;
  logic [IDX_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [TAG_WIDTH-1:0] r_tag;
  logic [WAY_W-1:0]     r_victim;

  logic [TAG_WIDTH-1:0] r_tag_arr   [SET_NUM][ASSOC_NUM];
  logic [ASSOC_NUM-1:0] r_valid_arr [SET_NUM];

  logic [ASSOC_NUM-1:0] w_set_valid;
  logic [ASSOC_NUM-1:0] w_hit_vec;
  logic                 w_hit;
  logic [WAY_W-1:0]     w_hit_way;
  logic                 w_any_inv;
  logic [WAY_W-1:0]     w_inv_way;
  logic [WAY_W-1:0]     w_victim;
  logic                 w_accept;
  logic                 w_fill;
  logic                 w_last;

  assign w_set_valid = r_valid_arr[r_idx];
  assign w_last      = (r_cnt == c_LAST_SET);
  assign w_accept    = (r_state == c_IDLE) && !flush_valid && req_valid;
  assign w_fill      = (r_state == c_REFILL_WAIT) && refill_done && !reset;

  generate
    for (genvar w = 0; w < ASSOC_NUM; w++) begin : g_way
      assign w_hit_vec[w] = w_set_valid[w] && (r_tag_arr[r_idx][w] == r_tag);
    end
  endgenerate

  // Descending scans leave the lowest matching way in the result.
  always_comb begin
    w_hit_way = '0;
    w_inv_way = '0;
    for (int w = ASSOC_NUM - 1; w >= 0; w--) begin
      if (w_hit_vec[w]) w_hit_way = WAY_W'(w);
      if (!w_set_valid[w]) w_inv_way = WAY_W'(w);
    end
  end

  assign w_hit     = |w_hit_vec;
  assign w_any_inv = ~&w_set_valid;
  assign w_victim  = w_any_inv ? w_inv_way : plru_lru;

  always_ff @(posedge clk) begin
    if (reset) r_state <= c_FLUSH;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_FLUSH:       if (w_last) w_next_state = c_IDLE;
      c_IDLE: begin
        if (flush_valid)    w_next_state = c_FLUSH;
        else if (req_valid) w_next_state = c_LOOKUP;
      end
      c_LOOKUP:      w_next_state = w_hit ? c_IDLE : c_MISS_REQ;
      c_MISS_REQ:    if (refill_req_ready) w_next_state = c_REFILL_WAIT;
      c_REFILL_WAIT: if (refill_done) w_next_state = c_IDLE;
      default:       w_next_state = c_FLUSH;
    endcase
  end

  // Flush counter rests at zero outside FLUSH so every walk starts at set 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_idx    <= '0;
      r_tag    <= '0;
      r_victim <= '0;
    end else begin
      if (r_state == c_FLUSH) r_cnt <= r_cnt + 1'b1;
      else                    r_cnt <= '0;
      if (w_accept) begin
        r_idx <= req_index;
        r_tag <= req_tag;
      end
      if ((r_state == c_LOOKUP) && !w_hit) r_victim <= w_victim;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && (r_state == c_FLUSH)) r_valid_arr[r_cnt] <= '0;
    if (w_fill) begin
      r_valid_arr[r_idx][r_victim] <= 1'b1;
      r_tag_arr[r_idx][r_victim]   <= r_tag;
    end
  end

  always_comb begin
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    resp_hit         = 1'b0;
    resp_way         = '0;
    refill_req_valid = 1'b0;
    refill_req_index = '0;
    refill_req_tag   = '0;
    refill_req_way   = '0;
    plru_index       = '0;
    plru_access      = '0;
    plru_update      = 1'b0;
    flush_done       = 1'b0;
    if (!reset) begin
      req_ready        = (r_state == c_IDLE) && !flush_valid;
      flush_done       = (r_state == c_FLUSH) && w_last;
      refill_req_valid = (r_state == c_MISS_REQ);
      refill_req_index = r_idx;
      refill_req_tag   = r_tag;
      refill_req_way   = r_victim;
      plru_index       = r_idx;
      if ((r_state == c_LOOKUP) && w_hit) begin
        resp_valid  = 1'b1;
        resp_hit    = 1'b1;
        resp_way    = w_hit_way;
        plru_update = 1'b1;
        plru_access = c_ONE_WAY << w_hit_way;
      end else if (w_fill) begin
        resp_valid  = 1'b1;
        resp_way    = r_victim;
        plru_update = 1'b1;
        plru_access = c_ONE_WAY << r_victim;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_tag_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cache_tag_ctrl
// Purpose  : Directed self-checking bench for cache_tag_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_tag_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_index;
  logic [19:0] req_tag;
  logic        resp_valid;
  logic        resp_hit;
  logic [1:0]  resp_way;
  logic        refill_req_valid;
  logic        refill_req_ready;
  logic [5:0]  refill_req_index;
  logic [19:0] refill_req_tag;
  logic [1:0]  refill_req_way;
  logic        refill_done;
  logic [5:0]  plru_index;
  logic [3:0]  plru_access;
  logic        plru_update;
  logic [1:0]  plru_lru;
  logic        flush_valid;
  logic        flush_done;

  int n_checks = 0;
  int n_errors = 0;

  cache_tag_ctrl #(
    .ASSOC_NUM(4),
    .SET_NUM(64),
    .TAG_WIDTH(20)
  ) u_dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_index(req_index),
    .req_tag(req_tag),
    .resp_valid(resp_valid),
    .resp_hit(resp_hit),
    .resp_way(resp_way),
    .refill_req_valid(refill_req_valid),
    .refill_req_ready(refill_req_ready),
    .refill_req_index(refill_req_index),
    .refill_req_tag(refill_req_tag),
    .refill_req_way(refill_req_way),
    .refill_done(refill_done),
    .plru_index(plru_index),
    .plru_access(plru_access),
    .plru_update(plru_update),
    .plru_lru(plru_lru),
    .flush_valid(flush_valid),
    .flush_done(flush_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic flush_watch(input string nm);
    int ready_hi = 0;
    int pulses   = 0;
    int pos      = 0;
    for (int i = 1; i <= 64; i++) begin
      if (req_ready) ready_hi++;
      if (flush_done) begin
        pulses++;
        pos = i;
      end
      cyc();
    end
    check({nm, "_ready_low_cycles"}, ready_hi, 0);
    check({nm, "_done_pulses"}, pulses, 1);
    check({nm, "_done_cycle"}, pos, 64);
    check({nm, "_ready_after"}, {31'd0, req_ready}, 1);
  endtask

  task automatic accept(input logic [5:0] idx, input logic [19:0] tag);
    req_index = idx;
    req_tag   = tag;
    req_valid = 1'b1;
    settle();
    check("accept_ready", {31'd0, req_ready}, 1);
    cyc();
    req_valid = 1'b0;
    settle();
  endtask

  task automatic miss_fill(input logic [5:0] idx, input logic [19:0] tag,
                           input logic [1:0] lru, input logic [1:0] exp_way);
    accept(idx, tag);
    plru_lru = lru;
    settle();
    check("miss_no_resp", {31'd0, resp_valid}, 0);
    check("miss_no_update", {31'd0, plru_update}, 0);
    cyc();
    check("miss_req_valid", {31'd0, refill_req_valid}, 1);
    check("miss_req_way", {30'd0, refill_req_way}, {30'd0, exp_way});
    check("miss_req_index", {26'd0, refill_req_index}, {26'd0, idx});
    check("miss_req_tag", {12'd0, refill_req_tag}, {12'd0, tag});
    refill_req_ready = 1'b1;
    cyc();
    refill_req_ready = 1'b0;
    refill_done = 1'b1;
    settle();
    check("fill_resp_valid", {31'd0, resp_valid}, 1);
    check("fill_resp_hit", {31'd0, resp_hit}, 0);
    check("fill_resp_way", {30'd0, resp_way}, {30'd0, exp_way});
    check("fill_access", {28'd0, plru_access}, 32'd1 << exp_way);
    check("fill_update", {31'd0, plru_update}, 1);
    cyc();
    refill_done = 1'b0;
    settle();
  endtask

  task automatic lookup_hit(input logic [5:0] idx, input logic [19:0] tag,
                            input logic [1:0] exp_way);
    accept(idx, tag);
    check("hit_resp_valid", {31'd0, resp_valid}, 1);
    check("hit_resp_hit", {31'd0, resp_hit}, 1);
    check("hit_resp_way", {30'd0, resp_way}, {30'd0, exp_way});
    check("hit_access", {28'd0, plru_access}, 32'd1 << exp_way);
    check("hit_plru_index", {26'd0, plru_index}, {26'd0, idx});
    check("hit_no_refill", {31'd0, refill_req_valid}, 0);
    cyc();
    check("hit_idle_no_refill", {31'd0, refill_req_valid}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    reset = 1'b1;
    req_valid = 1'b0;
    req_index = '0;
    req_tag = '0;
    refill_req_ready = 1'b0;
    refill_done = 1'b0;
    plru_lru = 2'd3;
    flush_valid = 1'b0;
    cyc();
    cyc();
    check("rst_req_ready", {31'd0, req_ready}, 0);
    check("rst_flush_done", {31'd0, flush_done}, 0);
    check("rst_refill_valid", {31'd0, refill_req_valid}, 0);
    check("rst_resp_valid", {31'd0, resp_valid}, 0);
    check("rst_plru_index", {26'd0, plru_index}, 0);
    check("rst_plru_update", {31'd0, plru_update}, 0);
    reset = 1'b0;
    settle();
    flush_watch("boot");

    // Cold miss with a stalled refill handshake
    accept(6'd5, 20'h12345);
    check("cold_no_resp", {31'd0, resp_valid}, 0);
    cyc();
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      if (!(refill_req_valid && refill_req_way == 2'd0 &&
            refill_req_index == 6'd5 && refill_req_tag == 20'h12345)) bad++;
      cyc();
    end
    check("cold_req_stable", bad, 0);
    check("cold_req_still_valid", {31'd0, refill_req_valid}, 1);
    refill_req_ready = 1'b1;
    refill_done = 1'b1;
    settle();
    check("cold_done_ignored", {31'd0, resp_valid}, 0);
    cyc();
    refill_req_ready = 1'b0;
    refill_done = 1'b0;
    settle();
    check("cold_wait_no_resp", {31'd0, resp_valid}, 0);
    check("cold_wait_req_low", {31'd0, refill_req_valid}, 0);
    cyc();
    refill_done = 1'b1;
    settle();
    check("cold_resp_valid", {31'd0, resp_valid}, 1);
    check("cold_resp_hit", {31'd0, resp_hit}, 0);
    check("cold_resp_way", {30'd0, resp_way}, 0);
    check("cold_access", {28'd0, plru_access}, 32'h1);
    check("cold_update", {31'd0, plru_update}, 1);
    cyc();
    refill_done = 1'b0;
    settle();
    check("cold_back_idle", {31'd0, req_ready}, 1);

    lookup_hit(6'd5, 20'h12345, 2'd0);

    // Fill set 9; lowest invalid way wins over plru_lru
    miss_fill(6'd9, 20'h00AAA, 2'd3, 2'd0);
    miss_fill(6'd9, 20'h00BBB, 2'd3, 2'd1);
    miss_fill(6'd9, 20'h00CCC, 2'd3, 2'd2);
    miss_fill(6'd9, 20'h00DDD, 2'd0, 2'd3);
    miss_fill(6'd9, 20'h0EEEE, 2'd2, 2'd2);
    lookup_hit(6'd9, 20'h0EEEE, 2'd2);
    lookup_hit(6'd9, 20'h00AAA, 2'd0);
    miss_fill(6'd9, 20'h00CCC, 2'd1, 2'd1);
    lookup_hit(6'd9, 20'h00DDD, 2'd3);

    // Flush requested during REFILL_WAIT is deferred to IDLE
    accept(6'd7, 20'hABCDE);
    cyc();
    check("fl_req_way", {30'd0, refill_req_way}, 0);
    refill_req_ready = 1'b1;
    cyc();
    refill_req_ready = 1'b0;
    flush_valid = 1'b1;
    settle();
    check("fl_wait_no_done", {31'd0, flush_done}, 0);
    check("fl_wait_not_ready", {31'd0, req_ready}, 0);
    cyc();
    refill_done = 1'b1;
    settle();
    check("fl_fill_resp", {31'd0, resp_valid}, 1);
    check("fl_fill_way", {30'd0, resp_way}, 0);
    cyc();
    refill_done = 1'b0;
    settle();
    check("fl_idle_ready_blocked", {31'd0, req_ready}, 0);
    cyc();
    flush_valid = 1'b0;
    settle();
    flush_watch("cmd");
    miss_fill(6'd5, 20'h12345, 2'd3, 2'd0);

    // Reset while a refill request is outstanding
    accept(6'd3, 20'h55555);
    cyc();
    check("mid_req_valid", {31'd0, refill_req_valid}, 1);
    reset = 1'b1;
    refill_done = 1'b1;
    refill_req_ready = 1'b1;
    cyc();
    check("mid_req_dropped", {31'd0, refill_req_valid}, 0);
    check("mid_no_resp", {31'd0, resp_valid}, 0);
    check("mid_no_update", {31'd0, plru_update}, 0);
    check("mid_plru_index", {26'd0, plru_index}, 0);
    reset = 1'b0;
    refill_done = 1'b0;
    refill_req_ready = 1'b0;
    settle();
    flush_watch("rst");
    miss_fill(6'd5, 20'h12345, 2'd3, 2'd0);
    lookup_hit(6'd5, 20'h12345, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
